// File: rtl/spiral_gen_param_if.sv
// rtl/spiral_gen_param_if.sv - pixel, animation-control and colour signals of the spiral generator
interface spiral_gen_param_if;
    logic       pattern_enable;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       next_frame;
    logic [2:0] step_size;
    logic       reverse;
    logic       palette_cycle;
    logic [5:0] rgb;

    modport master (
        output pattern_enable, x, y, active, next_frame, step_size, reverse, palette_cycle,
        input  rgb
    );

    modport slave (
        input  pattern_enable, x, y, active, next_frame, step_size, reverse, palette_cycle,
        output rgb
    );
endinterface

// File: rtl/spiral_gen_param.sv
// rtl/spiral_gen_param.sv - N-arm Manhattan spiral source with rotation and palette cycling
module spiral_gen_param #(
    parameter int NUM_ARMS       = 6,
    parameter int ROT_W          = 6,
    parameter int RADIUS_SHIFT   = 4,
    parameter int MIN_RADIUS     = 20,
    parameter int PALETTE_PERIOD = 8,
    parameter int CENTER_X       = 320,
    parameter int CENTER_Y       = 240
) (
    input  logic                clk,
    input  logic                rst,
    spiral_gen_param_if.slave   bus
);
    localparam logic [9:0] CX      = 10'(CENTER_X);
    localparam logic [9:0] CY      = 10'(CENTER_Y);
    localparam logic [9:0] MIN_R   = 10'(MIN_RADIUS);
    localparam logic [7:0] PAL_END = 8'(PALETTE_PERIOD - 1);
    localparam logic [3:0] ARMS    = 4'(NUM_ARMS);

    logic [ROT_W-1:0] rotation_offset;
    logic [1:0]       subframe_accum;
    logic [7:0]       frame_cnt;
    logic [2:0]       palette_offset;

    logic             frame_update;
    logic [2:0]       frac_sum;
    logic [ROT_W-1:0] delta;

    assign frame_update = bus.pattern_enable && bus.next_frame;
    assign frac_sum     = {1'b0, subframe_accum} + {1'b0, bus.step_size[1:0]};
    // delta is 0, 2 or 4: the integer step plus a carry out of the quarter-frame accumulator
    assign delta = ROT_W'({bus.step_size[2] & frac_sum[2], bus.step_size[2] ^ frac_sum[2], 1'b0});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rotation_offset <= '0;
            subframe_accum  <= '0;
            frame_cnt       <= '0;
            palette_offset  <= '0;
        end else if (frame_update) begin
            rotation_offset <= bus.reverse ? rotation_offset - delta : rotation_offset + delta;
            subframe_accum  <= frac_sum[1:0];
            if (bus.palette_cycle) begin
                if (frame_cnt == PAL_END) begin
                    frame_cnt      <= '0;
                    palette_offset <= palette_offset + 3'd1;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    logic       xl, yl;
    logic [9:0] dx, dy;

    assign xl = bus.x < CX;
    assign yl = bus.y < CY;
    assign dx = xl ? CX - bus.x : bus.x - CX;
    assign dy = yl ? CY - bus.y : bus.y - CY;

    logic [9:0] s1_radius;
    logic [2:0] s1_sector;
    logic       s1_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_radius <= '0;
            s1_sector <= '0;
            s1_active <= 1'b0;
        end else begin
            s1_radius <= dx + dy;
            s1_sector <= {~xl, ~yl, dx > dy};
            s1_active <= bus.active;
        end
    end

    logic [ROT_W-1:0] angle;
    logic [ROT_W:0]   phase;
    logic [2:0]       arm_index;
    logic             in_arm;
    logic [2:0]       pal_idx;
    logic [5:0]       pal_color;

    assign angle     = {s1_sector, {(ROT_W-3){1'b0}}} + rotation_offset;
    // extra top bit lets the radial term wrap the phase into the upper arms
    assign phase     = {1'b0, angle} - (ROT_W+1)'(s1_radius >> RADIUS_SHIFT);
    assign arm_index = phase[ROT_W -: 3];
    assign in_arm    = !phase[ROT_W-3] && ({1'b0, arm_index} < ARMS) && (s1_radius > MIN_R);
    assign pal_idx   = arm_index + palette_offset;

    always_comb begin
        pal_color = 6'b000000;
        case (pal_idx)
            3'd0: pal_color = 6'b010001;
            3'd1: pal_color = 6'b100011;
            3'd2: pal_color = 6'b111010;
            3'd3: pal_color = 6'b001110;
            3'd4: pal_color = 6'b011101;
            3'd5: pal_color = 6'b101111;
            3'd6: pal_color = 6'b110000;
            3'd7: pal_color = 6'b000111;
            default: pal_color = 6'b000000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rgb <= '0;
        end else begin
            bus.rgb <= (s1_active && in_arm) ? pal_color : 6'b000000;
        end
    end
endmodule

// File: tb/tb_spiral_gen_param.sv
// tb/tb_spiral_gen_param.sv - directed self-checking bench for spiral_gen_param
module tb_spiral_gen_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spiral_gen_param_if bus();
    spiral_gen_param_if bus4();

    assign bus4.pattern_enable = bus.pattern_enable;
    assign bus4.x              = bus.x;
    assign bus4.y              = bus.y;
    assign bus4.active         = bus.active;
    assign bus4.next_frame     = bus.next_frame;
    assign bus4.step_size      = bus.step_size;
    assign bus4.reverse        = bus.reverse;
    assign bus4.palette_cycle  = bus.palette_cycle;

    spiral_gen_param dut (.clk(clk), .rst(rst), .bus(bus));
    spiral_gen_param #(.NUM_ARMS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse();
        @(negedge clk);
        bus.next_frame = 1'b1;
        @(negedge clk);
        bus.next_frame = 1'b0;
    endtask

    task automatic pixel(input logic [9:0] px, input logic [9:0] py, input logic act);
        @(negedge clk);
        bus.x      = px;
        bus.y      = py;
        bus.active = act;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst                = 1'b1;
        bus.pattern_enable = 1'b1;
        bus.x              = 10'd0;
        bus.y              = 10'd0;
        bus.active         = 1'b0;
        bus.next_frame     = 1'b0;
        bus.step_size      = 3'b000;
        bus.reverse        = 1'b0;
        bus.palette_cycle  = 1'b0;
        #12;
        check("reset_rgb", 32'(bus.rgb), 0);
        check("reset_rot", 32'(dut.rotation_offset), 0);
        check("reset_pal", 32'(dut.palette_offset), 0);
        @(negedge clk);
        rst = 1'b0;

        pixel(10'd400, 10'd240, 1'b1);
        check("pix_400_240", 32'(bus.rgb), 32'b001110);
        check("pix_400_240_arms4", 32'(bus4.rgb), 32'b001110);
        pixel(10'd0, 10'd840, 1'b1);
        check("arm5_default", 32'(bus.rgb), 32'b101111);
        check("arm5_arms4", 32'(bus4.rgb), 0);
        pixel(10'd320, 10'd240, 1'b1);
        check("radius0", 32'(bus.rgb), 0);
        pixel(10'd400, 10'd240, 1'b0);
        check("inactive", 32'(bus.rgb), 0);

        bus.step_size = 3'b001;
        repeat (3) pulse();
        check("frac3_rot", 32'(dut.rotation_offset), 0);
        check("frac3_acc", 32'(dut.subframe_accum), 3);
        pulse();
        check("frac4_rot", 32'(dut.rotation_offset), 2);
        check("frac4_acc", 32'(dut.subframe_accum), 0);
        bus.pattern_enable = 1'b0;
        repeat (3) pulse();
        check("disabled_rot", 32'(dut.rotation_offset), 2);
        check("disabled_acc", 32'(dut.subframe_accum), 0);
        bus.pattern_enable = 1'b1;

        do_reset();
        bus.step_size = 3'b100;
        bus.reverse   = 1'b1;
        pulse();
        check("reverse_wrap", 32'(dut.rotation_offset), 62);
        bus.reverse = 1'b0;
        pulse();
        check("forward_wrap", 32'(dut.rotation_offset), 0);

        do_reset();
        bus.step_size = 3'b111;
        repeat (2) pulse();
        check("step7_rot", 32'(dut.rotation_offset), 6);
        check("step7_acc", 32'(dut.subframe_accum), 2);

        do_reset();
        bus.step_size     = 3'b000;
        bus.palette_cycle = 1'b1;
        repeat (7) pulse();
        check("pal_7", 32'(dut.palette_offset), 0);
        pulse();
        check("pal_8", 32'(dut.palette_offset), 1);
        check("pal_8_cnt", 32'(dut.frame_cnt), 0);
        pixel(10'd400, 10'd240, 1'b1);
        check("pal_pixel", 32'(bus.rgb), 32'b011101);
        bus.palette_cycle = 1'b0;
        repeat (20) pulse();
        check("pal_hold", 32'(dut.palette_offset), 1);
        check("pal_hold_cnt", 32'(dut.frame_cnt), 0);

        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_rgb", 32'(bus.rgb), 0);
        @(negedge clk);
        rst = 1'b0;
        pixel(10'd400, 10'd240, 1'b1);
        check("refill", 32'(bus.rgb), 32'b001110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spiral_gen_param.md
Name: spiral_gen_param

Overview:
Parametrised successor to the rotating spiral pattern source. It renders an N-arm Manhattan-distance spiral with configurable angular resolution and radial pitch. Rotation runs forward or reverse with fractional speed, and palette cycling rotates the colours across arms. Pixel output is a 2-stage registered pipeline that feeds the pattern mux alongside the other generators.

Parameters:
NUM_ARMS, 6, arms drawn (1..8); arm_index >= NUM_ARMS renders black
ROT_W, 6, rotation/angle width in bits (4..8)
RADIUS_SHIFT, 4, radial pitch: radius_scaled = radius >> RADIUS_SHIFT (0..9)
MIN_RADIUS, 20, pixels with radius <= MIN_RADIUS render black
PALETTE_PERIOD, 8, frames per palette_offset advance (1..255)
CENTER_X, 320, spiral centre x
CENTER_Y, 240, spiral centre y

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
pattern_enable  in  1  animation state advances only when high
x  in  10  pixel column
y  in  10  pixel row
active  in  1  visible-area flag
next_frame  in  1  one-cycle pulse per frame
step_size  in  3  rotation speed; [2] = 2 units/frame, [1:0] = quarter-frame fraction
reverse  in  1  1 = rotation decrements
palette_cycle  in  1  1 = palette offset advances
rgb  out  6  RRGGBB colour, registered

Behaviour:
- Reset (async, rst=1): rotation_offset, subframe_accum, frame_cnt, palette_offset, all pipeline regs = 0; rgb = 0 immediately.
- Frame update: occurs on a clock where pattern_enable && next_frame.
  - frac_sum = subframe_accum + step_size[1:0] (3 bits).
  - delta = 2*step_size[2] + 2*frac_sum[2].
  - rotation_offset <= rotation_offset ± delta mod 2^ROT_W; reverse=1 selects minus.
  - subframe_accum <= frac_sum[1:0].
  - Direction is sampled at the update; no other state changes on reversal.
- Palette: only when palette_cycle=1 at a frame update.
  - frame_cnt increments.
  - On the update where frame_cnt == PALETTE_PERIOD-1: frame_cnt <= 0 and palette_offset <= palette_offset+1 (3-bit wrap).
  - palette_cycle=0: frame_cnt and palette_offset hold.
- pattern_enable=0: all animation state holds. The pixel pipeline still runs.
- Stage 1 (registered):
  - xl = x<CENTER_X; yl = y<CENTER_Y.
  - dx, dy = absolute differences from centre.
  - radius = dx+dy (10 bits).
  - sector = {~xl, ~yl, dx>dy}.
  - active delayed one cycle.
- Stage 2 (registered to rgb):
  - angle = (sector << (ROT_W-3)) + rotation_offset, ROT_W bits wrap.
  - phase = {0,angle} - (radius>>RADIUS_SHIFT), truncated to ROT_W+1 bits.
  - arm_index = phase[ROT_W:ROT_W-2].
  - in_arm = phase[ROT_W-3]==0 && arm_index<NUM_ARMS && radius>MIN_RADIUS.
  - rgb <= (active_d && in_arm) ? PAL[(arm_index+palette_offset) mod 8] : 0.
- PAL[0..7] = 010001, 100011, 111010, 001110, 011101, 101111, 110000, 000111.
- Latency: x/y/active at edge n -> rgb valid after edge n+2; throughput 1 pixel/clock.
- Stage 2 uses the live rotation_offset and palette_offset. next_frame occurs in blanking, so no visible tearing.
- Wrap-around: rotation wraps mod 2^ROT_W in both directions. Phase subtraction wraps mod 2^(ROT_W+1).
- Simultaneous events: next_frame with a reverse change applies the new direction at that update. Reset mid-frame zeroes rgb at once; pipeline refills within 2 clocks after release.

Test Plan:
- Reset -> rgb=0, rotation_offset=0, palette_offset=0; release, then 2 clocks at x=400,y=240,active=1 -> rgb=001110 (sector 7, angle 56, phase 51, arm 3).
- step_size=3'b001, 4 frame pulses, pattern_enable=1 -> rotation_offset=2, subframe_accum=0 after the 4th; pulses with pattern_enable=0 -> no change.
- step_size=3'b100, reverse=1, from reset, 1 pulse -> rotation_offset=62 (ROT_W=6); reverse=0, 1 pulse -> 0.
- palette_cycle=1, 8 pulses -> palette_offset=1; at x=400,y=240 -> rgb=011101; palette_cycle=0 for 20 pulses -> offset stays 1.
- x=320,y=240 (radius 0) or active=0 -> rgb=000000 two clocks later.
- NUM_ARMS=4 build, pixel with arm_index 5 -> rgb=000000; same pixel in default build -> non-zero.
